// File: rtl/sw_pkg.sv
// sw_pkg: shared switch flit layout, port count and output-arbiter state type
package sw_pkg;
   localparam int SW_PKTW     = 8;
   localparam int SW_NPORT    = 4;
   localparam int SW_DW       = SW_PKTW + 1;
   localparam int SW_DST_LSB  = 0;
   localparam int SW_DST_W    = 2;
   localparam int SW_LAST_BIT = SW_PKTW;
   typedef enum logic {S_IDLE, S_BUSY} state_t;
endpackage

// File: rtl/sw_out_arb_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
   parameter int NPORT = 4,
   localparam int IW = NPORT > 1 ? $clog2(NPORT) : 1
) (
   input  logic [NPORT-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [NPORT-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);
   // scan from ptr upward with wrap-around; the first hit wins
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NPORT) j = j - NPORT;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/sw_out_arb.sv
// sw_out_arb: packet-atomic round-robin output arbiter with registered valid/ready stage
module sw_out_arb #(
   parameter int NPORT    = sw_pkg::SW_NPORT,
   parameter int PORT_ID  = 0,
   parameter int DW       = sw_pkg::SW_DW,
   parameter int DST_LSB  = sw_pkg::SW_DST_LSB,
   parameter int DST_W    = sw_pkg::SW_DST_W,
   parameter int LAST_BIT = sw_pkg::SW_LAST_BIT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NPORT-1:0][DW-1:0]  in_data,
   input  logic [NPORT-1:0]          in_empty,
   output logic [NPORT-1:0]          re,
   output logic [DW-1:0]             out_data,
   output logic                      out_valid,
   input  logic                      out_ready
);
   import sw_pkg::*;
   localparam int IW = NPORT > 1 ? $clog2(NPORT) : 1;
   state_t            state, state_n;
   logic [IW-1:0]     ptr, ptr_n, lock, lock_n, gidx, sel;
   logic [NPORT-1:0]  req, gnt;
   logic              any, slot_free, pop;
   logic [DW-1:0]     flit;
   // an input requests only when its head flit is addressed to this output
   always_comb begin
      req = '0;
      for (int i = 0; i < NPORT; i++)
         req[i] = !in_empty[i] && in_data[i][DST_LSB +: DST_W] == DST_W'(PORT_ID);
   end
   assign slot_free = !out_valid || out_ready;
   rr_arbiter #(.NPORT(NPORT)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx),
      .any (any)
   );
   // pop decision and next state; a locked packet ignores body-flit destinations
   always_comb begin
      sel     = state == S_BUSY ? lock : gidx;
      pop     = !rst && slot_free && (state == S_BUSY ? !in_empty[lock] : any);
      re      = !pop ? '0 : state == S_BUSY ? NPORT'(1) << lock : gnt;
      flit    = in_data[sel];
      state_n = state;
      lock_n  = lock;
      ptr_n   = ptr;
      if (pop && state == S_IDLE && !flit[LAST_BIT]) begin
         state_n = S_BUSY;
         lock_n  = gidx;
      end
      if (pop && flit[LAST_BIT]) begin
         state_n = S_IDLE;
         ptr_n   = int'(sel) == NPORT - 1 ? '0 : sel + 1'b1;
      end
   end
   // grant state: reset drops any held lock and restarts the rotation at input 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         lock  <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         lock  <= lock_n;
         ptr   <= ptr_n;
      end
   end
   // output register: load on pop, otherwise drain when the consumer takes the flit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= flit;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sw_out_arb.sv
// tb_sw_out_arb: directed bench with FIFO-queue model of the output arbiter
module tb_sw_out_arb;
   localparam int NP = 4, W = 9, D = 32;
   logic clk = 1'b0, rst = 1'b0, out_ready = 1'b1;
   logic [NP-1:0][W-1:0] in_data;
   logic [NP-1:0] in_empty, re;
   logic [W-1:0] out_data;
   logic out_valid;
   logic [W-1:0] mem [NP][D];
   int hd [NP];
   int tl [NP];
   int checks = 0, errors = 0;
   logic m_valid = 1'b0, m_busy = 1'b0;
   logic [W-1:0] m_data = '0;
   int m_lock = 0, m_ptr = 0, pi;
   logic [NP-1:0] exp_re = '0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < NP; i++) begin : g_fifo
      assign in_empty[i] = hd[i] == tl[i];
      assign in_data[i]  = mem[i][hd[i] % D];
   end

   sw_out_arb #(.NPORT(NP), .PORT_ID(0), .DW(W), .DST_LSB(0), .DST_W(2), .LAST_BIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_empty  (in_empty),
      .re        (re),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   function automatic logic [W-1:0] mk(input bit last, input int dst, input int pl);
      return {last, 6'(pl), 2'(dst)};
   endfunction

   function automatic logic [NP-1:0] model_re();
      logic [NP-1:0] r;
      r = '0;
      if (m_valid && !out_ready) return r;
      if (m_busy) begin
         if (hd[m_lock] != tl[m_lock]) r[m_lock] = 1'b1;
      end else begin
         for (int k = 0; k < NP; k++) begin
            int j;
            j = (m_ptr + k) % NP;
            if (hd[j] != tl[j] && mem[j][hd[j] % D][1:0] == 2'd0) begin
               r[j] = 1'b1;
               break;
            end
         end
      end
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   task automatic push(input int p, input logic [W-1:0] f);
      mem[p][tl[p] % D] = f;
      tl[p] = tl[p] + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   always_comb begin
      pi = 0;
      for (int i = 0; i < NP; i++) if (exp_re[i]) pi = i;
   end

   // compare every cycle against the queue model
   always @(negedge clk) begin
      if (rst) exp_re <= '0;
      else begin
         exp_re <= model_re();
         chk("re", 32'(re), 32'(model_re()));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) chk("out_data", 32'(out_data), 32'(m_data));
      end
   end

   // model: FIFOs pop by the expected strobe; packets stay atomic per grant
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) hd[i] <= tl[i];
         m_valid <= 1'b0;
         m_data  <= '0;
         m_busy  <= 1'b0;
         m_lock  <= 0;
         m_ptr   <= 0;
      end else if (exp_re != '0) begin
         hd[pi]  <= hd[pi] + 1;
         m_data  <= mem[pi][hd[pi] % D];
         m_valid <= 1'b1;
         if (!m_busy) begin
            if (!mem[pi][hd[pi] % D][8]) begin
               m_busy <= 1'b1;
               m_lock <= pi;
            end else m_ptr <= (pi + 1) % NP;
         end else if (mem[pi][hd[pi] % D][8]) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_lock + 1) % NP;
         end
      end else if (out_ready) m_valid <= 1'b0;
   end

   initial begin
      for (int p = 0; p < NP; p++) begin
         hd[p] = 0;
         tl[p] = 0;
         for (int a = 0; a < D; a++) mem[p][a] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_re", 32'(re), 0);
      rst = 1'b0;
      // single-flit packet at input 2, then ptr=3 favours input 3 over input 0
      push(2, mk(1, 0, 5));
      @(negedge clk);
      chk("t1_re", 32'(re), 32'b0100);
      @(posedge clk);
      #1;
      push(0, mk(1, 0, 6));
      push(3, mk(1, 0, 7));
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'h114);
      chk("t1_ptr_re", 32'(re), 32'b1000);
      idle(4);
      // two 3-flit packets: no interleave, no gap; body destinations ignored
      reset_dut();
      for (int f = 0; f < 3; f++) begin
         push(0, mk(f == 2, f == 0 ? 0 : 3, 8 + f));
         push(1, mk(f == 2, f == 0 ? 0 : 3, 16 + f));
      end
      @(negedge clk);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t2_valid", 32'(out_valid), 1);
         chk("t2_seq", 32'(out_data),
             32'(c < 3 ? mk(c == 2, c == 0 ? 0 : 3, 8 + c) : mk(c == 5, c == 3 ? 0 : 3, 13 + c)));
      end
      idle(2);
      // packet for another port is never popped
      reset_dut();
      push(1, mk(0, 2, 1));
      push(1, mk(1, 2, 2));
      repeat (4) begin
         @(negedge clk);
         chk("t3_re", 32'(re), 0);
         chk("t3_valid", 32'(out_valid), 0);
      end
      // backpressure in cycles 2-5 of a 4-flit packet
      reset_dut();
      for (int f = 0; f < 4; f++) push(0, mk(f == 3, 0, 32 + f));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t4_hold", 32'(out_data), 32'(mk(0, 0, 33)));
         chk("t4_re", 32'(re), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("t4_resume_re", 32'(re), 32'b0001);
      @(negedge clk);
      chk("t4_f2", 32'(out_data), 32'(mk(0, 0, 34)));
      @(negedge clk);
      chk("t4_f3", 32'(out_data), 32'(mk(1, 0, 35)));
      idle(2);
      // single-flit streams on all inputs rotate the grant
      reset_dut();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) push(p, mk(1, 0, p * 4 + r));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t5_rot", 32'(re), 32'(1) << (c % 4));
      end
      idle(6);
      // async reset mid-packet drops the lock and the rotation pointer
      reset_dut();
      push(1, mk(1, 0, 40));
      @(posedge clk);
      #1;
      for (int f = 0; f < 3; f++) push(2, mk(f == 2, 0, 44 + f));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_re", 32'(re), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      push(1, mk(1, 0, 50));
      push(3, mk(1, 0, 51));
      @(negedge clk);
      chk("t6_after", 32'(re), 32'b0010);
      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sw_out_arb.md
# sw_out_arb

Output-port arbiter for the switch. It sits directly downstream of the per-input packet FIFOs. It watches each FIFO head, selects one input whose head flit is addressed to this output, and pops that input's flits one per cycle into a registered valid/ready output stage. Once a packet starts it holds the grant until the packet's tail flit has gone through, so flits from different packets never interleave on one output.

## Interface
Parameters:
- NPORT, 4: number of input FIFOs arbitrated.
- PORT_ID, 0: output port number this instance serves.
- DW, `PKTW+1: flit width; equals the FIFO data width.
- DST_LSB, 0: LSB of the destination field in a flit.
- DST_W, 2: destination field width; NPORT <= 2**DST_W.
- LAST_BIT, `PKTW: flit bit that marks the tail flit of a packet (1 = tail).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NPORT x DW  head flit of each input FIFO (its `out`); meaningful only when the matching in_empty is 0.
- in_empty  in  NPORT  FIFO empty flags.
- re  out  NPORT  one-hot pop strobes to the FIFOs; combinational.
- out_data  out  DW  registered output flit.
- out_valid  out  1  out_data holds a flit.
- out_ready  in  1  the downstream stage accepts the flit this cycle.

## Operation
- req[i] = !in_empty[i] && in_data[i][DST_LSB +: DST_W] == PORT_ID.
- slot_free = !out_valid || out_ready.
- States:
  - IDLE (reset state), with ptr = 0.
  - BUSY(lock), where lock is the index of the input holding the grant.
- IDLE:
  - If some req[i] is set, the round-robin arbiter picks the first requesting input searching from ptr upward, with wrap-around; this is g.
  - If slot_free, assert re[g] and load in_data[g] into the output register.
  - If the popped flit has LAST_BIT = 0, go to BUSY(g).
  - If LAST_BIT = 1 (single-flit packet), stay in IDLE and set ptr = (g+1) mod NPORT.
  - If slot_free is 0, no pop happens and the state does not change. The grant is re-evaluated the next cycle and is not sticky.
- BUSY(lock):
  - The destination field of body flits is ignored.
  - If !in_empty[lock] && slot_free, assert re[lock] and load the flit.
  - When the loaded flit has LAST_BIT = 1, go to IDLE and set ptr = (lock+1) mod NPORT.
  - If the locked FIFO is empty mid-packet, wait in BUSY and emit nothing. Other inputs stay blocked.
- Output register:
  - On a pop, out_data <= flit and out_valid <= 1.
  - Otherwise, if out_ready, out_valid <= 0 and out_data holds its value.
- At most one bit of re is high per cycle. re is never asserted for an empty FIFO, and never while out_valid && !out_ready.

## Timing
- Reset values: out_valid = 0, out_data = 0, state = IDLE, ptr = 0. re = 0 for as long as rst is high.
- Latency: a flit at a FIFO head in cycle t with slot_free pops in cycle t. It appears on out_data with out_valid = 1 in cycle t+1.
- Throughput: one flit per cycle while out_ready = 1. There is no bubble between back-to-back packets, because IDLE arbitrates combinationally in the same cycle the previous tail flit left.
- Backpressure: out_data and out_valid stay stable while out_valid && !out_ready.
- Reset mid-packet: the lock is dropped and the state returns to IDLE. The input FIFOs share rst, so no partial packet is stranded.

## Structure
- The package sw_pkg holds the shared definitions:
  - NPORT and the flit field positions (DST_LSB, DST_W, LAST_BIT).
  - The state typedef: enum {S_IDLE, S_BUSY}.
- Sub-module rr_arbiter(NPORT) takes req and ptr and returns a one-hot grant plus its index. It is purely combinational. The ptr register lives in sw_out_arb.
- The FIFO's second peek output (out2) is not used by this block.

## Test plan
- Single-flit packet, LAST_BIT = 1, dest = PORT_ID, at input 2 in cycle 0 with out_ready = 1 → re = 4'b0100 in cycle 0; out_valid = 1 with that flit in cycle 1; ptr = 3.
- Inputs 0 and 1 both hold 3-flit packets for this port from cycle 0 → output is three flits of input 0 in cycles 1–3, then three flits of input 1 in cycles 4–6, with no interleave and no gap.
- Input 1 holds a 2-flit packet with dest ≠ PORT_ID → re stays 0 and out_valid stays 0.
- out_ready = 0 for cycles 2–5 during a 4-flit packet → out_data stays constant, re = 0 in cycles 2–5, transfer resumes in cycle 6 and no flit is lost or duplicated.
- All four inputs hold a stream of single-flit packets → grants rotate 0, 1, 2, 3, 0 on consecutive cycles.
- rst pulsed asynchronously in BUSY mid-packet → out_valid = 0 and re = 0 immediately; after rst releases, the next packet is granted starting from input 0.
